// File: rtl/reg_dump_seq.sv
// Debug read-out sequencer: walks the register bank read port over an inclusive,
// wrapping address range and streams each captured value as one valid/ready beat.
module reg_dump_seq #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] remaining, remaining_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [ADDR_W-1:0] rf_addr_n, out_addr_n;
  logic [DATA_W-1:0] out_data_n;
  logic              out_valid_n, busy_n, done_n;

  assign dbg_state = state;

  // rst_n is active-high here: 1 holds the block in reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      rf_addr   <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      rf_addr   <= rf_addr_n;
      remaining <= remaining_n;
      wait_cnt  <= wait_cnt_n;
      out_valid <= out_valid_n;
      out_addr  <= out_addr_n;
      out_data  <= out_data_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Stream contract: a beat transfers on a rising edge where out_valid & out_ready
  // are both high and abort is low; while out_valid is high and the beat has not
  // transferred, out_addr/out_data are held unchanged.
  always_comb begin
    state_n     = state;
    rf_addr_n   = rf_addr;
    remaining_n = remaining;
    wait_cnt_n  = wait_cnt;
    out_valid_n = out_valid;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    busy_n      = busy;
    done_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n     = ST_WAIT;
          rf_addr_n   = first_addr;
          remaining_n = last_addr - first_addr;
          wait_cnt_n  = CNT_RELOAD;
          busy_n      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_n     = ST_IDLE;
          out_valid_n = 1'b0;
          busy_n      = 1'b0;
        end else if (wait_cnt != '0) begin
          wait_cnt_n = wait_cnt - CNT_W'(1);
        end else begin
          out_data_n  = rf_data;
          out_addr_n  = rf_addr;
          out_valid_n = 1'b1;
          state_n     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_n     = ST_IDLE;
          out_valid_n = 1'b0;
          busy_n      = 1'b0;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          if (remaining == '0) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            rf_addr_n   = rf_addr + ADDR_W'(1);
            remaining_n = remaining - ADDR_W'(1);
            wait_cnt_n  = CNT_RELOAD;
            state_n     = ST_WAIT;
          end
        end
      end
      default: begin
        state_n     = ST_IDLE;
        out_valid_n = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_seq.sv
// Directed bench for reg_dump_seq: bank model on the read port, expected beats
// queued at start time and popped as beats are accepted.
module tb_reg_dump_seq;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic [DW-1:0]    bank [16];
  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  int done_cnt = 0;

  reg_dump_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Bank read port updates on the falling edge.
  always @(negedge clk) rf_data <= bank[rf_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepted beats are sampled mid-cycle, before the edge that transfers them.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        logic [AW+DW-1:0] e;
        beat_cnt++;
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", 64'(out_addr), 64'(e[AW+DW-1:DW]));
          chk("beat_data", 64'(out_data), 64'(e[DW-1:0]));
          chk("beat_rf_addr", 64'(rf_addr), 64'(e[AW+DW-1:DW]));
        end
      end
    end
  end

  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] n;
    logic [AW-1:0] a;
    n = l - f;
    a = f;
    for (int i = 0; i <= int'(n); i++) begin
      exp_q.push_back({a, bank[a]});
      a = a + AW'(1);
    end
    first_addr = f;
    last_addr  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(tag, 64'(seen), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    tick();
    chk({tag, "_pulse_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_addr"}, 64'(rf_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int b0;
    int d0;
    int found;
    for (int i = 0; i < 16; i++) bank[i] = '0;
    bank[1] = 32'd1; bank[2] = 32'd22; bank[3] = 32'd349;
    bank[4] = 32'd56; bank[9] = 32'd10;
    for (int i = 5; i < 9; i++) bank[i] = 32'($urandom_range(1000, 1));

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b0;
    tick();

    // Range 1..4 with latency checks
    start_dump(4'd1, 4'd4);
    chk("lat_rf_addr", 64'(rf_addr), 64'd1);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_valid_low", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid_high", 64'(out_valid), 64'd1);
    chk("lat_out_data", 64'(out_data), 64'd1);
    wait_done("range_1_4", 40);
    chk("range_1_4_beats", 64'(beat_cnt), 64'd4);

    // Single beat 9..9
    b0 = beat_cnt;
    start_dump(4'd9, 4'd9);
    wait_done("range_9_9", 20);
    tick(); tick(); tick();
    chk("range_9_9_beats", 64'(beat_cnt - b0), 64'd1);

    // Wrapping range 15..1
    b0 = beat_cnt;
    start_dump(4'd15, 4'd1);
    wait_done("range_15_1", 30);
    chk("range_15_1_beats", 64'(beat_cnt - b0), 64'd3);

    // Backpressure on first beat of 2..3, bank write during stall
    out_ready = 1'b0;
    start_dump(4'd2, 4'd3);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid) found = 1; else tick();
    end
    chk("bp_valid_seen", 64'(found), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) bank[2] = 32'd99;
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_addr_hold", 64'(out_addr), 64'd2);
      chk("bp_data_hold", 64'(out_data), 64'd22);
      tick();
    end
    bank[2] = 32'd22;
    out_ready = 1'b1;
    wait_done("backpressure", 30);

    // Abort during SEND of beat 2 of 1..4
    start_dump(4'd1, 4'd4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_addr == 4'd2) found = 1; else tick();
    end
    chk("abort_beat2_seen", 64'(found), 64'd1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rf_addr_hold", 64'(rf_addr), 64'd2);
    exp_q.delete();
    tick(); tick(); tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    start_dump(4'd2, 4'd2);
    wait_done("after_abort", 20);

    // Abort with start in IDLE: start ignored
    abort = 1'b1;
    first_addr = 4'd3; last_addr = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", 64'(busy), 64'd0);
    tick(); tick();

    // Async reset during WAIT
    start_dump(4'd1, 4'd4);
    chk("rst_in_wait_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b0;
    tick();

    // Start while busy is ignored
    b0 = beat_cnt;
    start_dump(4'd1, 4'd4);
    tick();
    first_addr = 4'd5; last_addr = 4'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_while_busy", 40);
    tick(); tick(); tick(); tick();
    chk("start_while_busy_beats", 64'(beat_cnt - b0), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
